// File: rtl/mul_wb_unit.sv
// Sequential 32x32 multiplier with register-file write-back. It does radix-2 shift-add over
// 32 cycles, then writes the low word and, for long multiplies, the high word to dest+1.
module mul_wb_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_long,
  input  logic        is_signed,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [3:0]  dest,
  output logic        mul_freeze,
  output logic        wb_wb_en,
  output logic [31:0] wb_value,
  output logic [3:0]  wb_dest,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] prod_q;
  logic [3:0]  dest_q;
  logic        long_q;
  logic        neg_q;

  logic [31:0] mag_a_d;
  logic [31:0] mag_b_d;
  logic        neg_d;
  logic [63:0] sum_d;
  logic [63:0] prod_d;

  // Magnitude of a two's-complement word; 0x80000000 maps to 2^31 as an unsigned value.
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
    magnitude = (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

  assign mag_a_d = magnitude(operand_a, is_signed);
  assign mag_b_d = magnitude(operand_b, is_signed);
  assign neg_d   = is_signed & (operand_a[31] ^ operand_b[31]);

  // One multiplier bit per cycle; the sign fix-up folds into the last add.
  assign sum_d  = prod_q + (mplier_q[0] ? mcand_q : 64'd0);
  assign prod_d = (cnt_q == 5'd31 && neg_q) ? (~sum_d + 64'd1) : sum_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      prod_q   <= 64'd0;
      dest_q   <= 4'd0;
      long_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= {32'd0, mag_a_d};
            mplier_q <= mag_b_d;
            prod_q   <= 64'd0;
            cnt_q    <= 5'd0;
            dest_q   <= dest;
            long_q   <= is_long;
            neg_q    <= neg_d;
            state_q  <= CALC;
          end
        end
        CALC: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= WB_LO;
        end
        WB_LO: state_q <= long_q ? WB_HI : IDLE;
        WB_HI: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; the stall also covers the accepting IDLE cycle.
  assign mul_freeze = rst & ((state_q != IDLE) | start);
  assign wb_wb_en   = (state_q == WB_LO) | (state_q == WB_HI);
  assign wb_value   = (state_q == WB_LO) ? prod_q[31:0] :
                      (state_q == WB_HI) ? prod_q[63:32] : 32'd0;
  assign wb_dest    = (state_q == WB_LO) ? dest_q :
                      (state_q == WB_HI) ? dest_q + 4'd1 : 4'd0;
  assign done       = ((state_q == WB_LO) & ~long_q) | (state_q == WB_HI);

endmodule

// File: tb/tb_mul_wb_unit.sv
// Randomized bench for mul_wb_unit: products come from plain 64-bit arithmetic and
// every cycle of each operation is compared against the expected write-back timeline.
module tb_mul_wb_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_long;
  logic        is_signed;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  dest;
  logic        mul_freeze;
  logic        wb_wb_en;
  logic [31:0] wb_value;
  logic [3:0]  wb_dest;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  mul_wb_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_long    (is_long),
    .is_signed  (is_signed),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .dest       (dest),
    .mul_freeze (mul_freeze),
    .wb_wb_en   (wb_wb_en),
    .wb_value   (wb_value),
    .wb_dest    (wb_dest),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic exp_freeze);
    chk({tag, "_freeze"}, mul_freeze, exp_freeze);
    chk({tag, "_wben"},   wb_wb_en,   1'b0);
    chk({tag, "_value"},  wb_value,   32'd0);
    chk({tag, "_dest"},   wb_dest,    4'd0);
    chk({tag, "_done"},   done,       1'b0);
  endtask

  // Called at a negedge. busy_at / rst_at are cycle indices after the capture edge (-1 = unused).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] d,
                        input logic lg, input logic sg, input int busy_at, input int rst_at);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    logic [3:0]  exp_dest;
    logic [31:0] exp_val;
    logic        exp_en, exp_done;
    int          dn, last, stray;

    if (sg) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      p  = sa * sb;
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end

    operand_a = a; operand_b = b; dest = d; is_long = lg; is_signed = sg; start = 1'b1;
    #1 chk("freeze_on_start", mul_freeze, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom; dest = 4'($urandom); is_long = ~lg;
    last = lg ? 33 : 32;
    dn = 0;
    for (int i = 0; i <= last; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      exp_en   = (i >= 32);
      exp_val  = (i == 32) ? p[31:0] : (i == 33) ? p[63:32] : 32'd0;
      exp_dest = (i == 32) ? d : (i == 33) ? d + 4'd1 : 4'd0;
      exp_done = (i == last);
      chk("busy_freeze", mul_freeze, 1'b1);
      chk("wb_en",    wb_wb_en, exp_en);
      chk("wb_value", wb_value, exp_val);
      chk("wb_dest",  wb_dest,  exp_dest);
      chk("done",     done,     exp_done);
      if (done) dn++;
      if (i == busy_at) begin
        start = 1'b1; operand_a = ~a; operand_b = b + 32'd5; dest = d + 4'd7; is_long = ~lg;
      end else if (i == busy_at + 1) begin
        start = 1'b0;
      end
      if (i == rst_at) begin
        rst = 1'b0;
        #1 chk_idle_outputs("rst_async", 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        stray = 0;
        for (int k = 0; k < 40; k++) begin
          @(posedge clk);
          @(negedge clk);
          if (wb_wb_en || done || mul_freeze) stray++;
        end
        chk("no_wb_after_rst", stray, 0);
        return;
      end
    end
    chk("done_count", dn, 1);
    @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("back_idle", 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b0; start = 1'b0; is_long = 1'b0; is_signed = 1'b0;
    operand_a = 32'd0; operand_b = 32'd0; dest = 4'd0;
    #3 chk_idle_outputs("reset", 1'b0);
    start = 1'b1;
    #1 chk("reset_freeze_start", mul_freeze, 1'b0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_op(32'd7, 32'd6, 4'd3, 1'b0, 1'b0, -1, -1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 1'b1, 1'b0, -1, -1);
    run_op(32'hFFFFFFFF, 32'd1, 4'd15, 1'b1, 1'b1, -1, -1);
    run_op(32'h80000000, 32'h80000000, 4'd2, 1'b1, 1'b1, -1, -1);
    run_op(32'hFFFFFFFD, 32'd9, 4'd6, 1'b0, 1'b1, -1, -1);
    run_op(32'd7, 32'd6, 4'd3, 1'b0, 1'b0, 10, -1);
    run_op(32'h12345678, 32'h9ABCDEF0, 4'd8, 1'b1, 1'b0, -1, 20);
    run_op(32'd100, 32'd200, 4'd1, 1'b0, 1'b0, -1, -1);
    run_op(32'hDEADBEEF, 32'h80000001, 4'd9, 1'b1, 1'b1, -1, 32);
    run_op(32'h0, 32'hFFFFFFFF, 4'd14, 1'b1, 1'b1, -1, -1);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      run_op(ra, rb, 4'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
